// File: rtl/inst_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master drives requests and consumes encoded words.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        out_err;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7,
    output rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_last, out_err
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7,
    input  rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_inst, out_last, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs fields into words,
// checks immediates and expands LI into LUI+ADDI.
module inst_encoder #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input logic          clk,
  input logic          rst,
  inst_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    HOLD2 = 2'd2
  } state_t;

  state_t      state;
  logic        valid_q;
  logic [31:0] inst_q;
  logic        last_q;
  logic        err_q;
  logic [31:0] addi_q;

  logic [31:0] imm;
  logic [31:0] hi_sum;
  logic        fits12;
  logic        b_ok;
  logic        j_ok;
  logic        accept;
  logic        drain;

  logic [31:0] enc_word;
  logic [31:0] enc_addi;
  logic        enc_two;
  logic        enc_err;

  assign imm    = bus.imm;
  assign hi_sum = imm + 32'h800;
  assign fits12 = imm[31:11] == {21{imm[11]}};
  assign b_ok   = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign j_ok   = (imm[31:20] == {12{imm[20]}}) && !imm[0];

  // in_ready follows out_ready combinationally so HOLD can refill
  // in the same cycle it drains; forced low while in reset.
  assign bus.in_ready = !rst &&
    ((state == IDLE) || (state == HOLD && bus.out_ready));

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = valid_q && bus.out_ready;

  assign bus.out_valid = valid_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_last  = last_q;
  assign bus.out_err   = err_q;

  // Encode the incoming request and flag unencodable immediates.
  always_comb begin
    enc_word = 32'd0;
    enc_addi = 32'd0;
    enc_two  = 1'b0;
    enc_err  = 1'b0;
    unique case (bus.fmt)
      3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1,
                        bus.funct3, bus.rd, bus.opcode};
      3'd1: begin
        enc_word = {imm[11:0], bus.rs1, bus.funct3,
                    bus.rd, bus.opcode};
        enc_err  = !fits12;
      end
      3'd2: begin
        enc_word = {imm[11:5], bus.rs2, bus.rs1,
                    bus.funct3, imm[4:0], bus.opcode};
        enc_err  = !fits12;
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1,
                    bus.funct3, imm[4:1], imm[11], bus.opcode};
        enc_err  = !b_ok;
      end
      3'd4: begin
        enc_word = {imm[31:12], bus.rd, bus.opcode};
        enc_err  = imm[11:0] != 12'd0;
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11],
                    imm[19:12], bus.rd, bus.opcode};
        enc_err  = !j_ok;
      end
      3'd6: begin
        if (fits12) begin
          enc_word = {imm[11:0], 5'd0, 3'd0, bus.rd, 7'h13};
        end else begin
          enc_word = {hi_sum[31:12], bus.rd, 7'h37};
          enc_addi = {imm[11:0], bus.rd, 3'd0, bus.rd, 7'h13};
          enc_two  = imm[11:0] != 12'd0;
        end
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) begin
      enc_word = NOP_INST;
      enc_two  = 1'b0;
    end
  end

  // Output FSM: one registered beat, plus a parked ADDI for LI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      addi_q  <= 32'd0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (accept) begin
            state   <= enc_two ? HOLD2 : HOLD;
            valid_q <= 1'b1;
            inst_q  <= enc_word;
            last_q  <= !enc_two;
            err_q   <= enc_err;
            addi_q  <= enc_addi;
          end else if (drain) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        HOLD2: begin
          if (drain) begin
            state  <= HOLD;
            inst_q <= addi_q;
            last_q <= 1'b1;
            err_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the RV32I pipeline, the inverse of the pipeline's immediate extraction. It packs opcode, register, funct and 32-bit immediate fields into 32-bit instruction words and checks that each immediate is representable. It also expands the `LI` pseudo-op into LUI+ADDI. It sits between the on-chip test-program generator or debug loader and instruction memory, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `NOP_INST`, default 32'h00000013: word emitted in place of an unencodable request.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted this cycle when `in_valid && in_ready`.
- `fmt` in 3: format select. 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=reserved.
- `opcode` in 7: opcode placed in [6:0]. Ignored for LI.
- `funct3` in 3, `funct7` in 7: function fields. `funct7` is used by R only.
- `rd`, `rs1`, `rs2` in 5 each: register fields.
- `imm` in 32: immediate as a signed byte value (U: full 32-bit value).
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_inst` out 32: encoded word.
- `out_last` out 1: final beat of a request.
- `out_err` out 1: beat replaces an unencodable request.

## Operation
Field placement:
- R: `funct7`,`rs2`,`rs1`,`funct3`,`rd`,`opcode`.
- I: imm[11:0]→[31:20]. Legal range −2048..2047.
- S: imm[11:5]→[31:25], imm[4:0]→[11:7]. Range as I.
- B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7. imm[0] must be 0. Range −4096..4094.
- U: imm[31:12]→[31:12]. imm[11:0] must be 0.
- J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12]. imm[0] must be 0. Range −2^20..2^20−2.

LI expansion:
- If imm fits 12-bit signed: one beat, ADDI rd,x0,imm (opcode 7'h13, funct3 0).
- Otherwise: hi=(imm+32'h800)>>12, taking bits [31:12] of the 32-bit sum with wrap.
- If imm[11:0]==0: one beat, LUI rd,hi (opcode 7'h37).
- Else two beats: LUI rd,hi, then ADDI rd,rd,imm[11:0].

Errors:
- An out-of-range or misaligned immediate, or fmt=7, produces one beat: `out_inst`=`NOP_INST`, `out_err`=1, `out_last`=1.
- The request is consumed; no other side effects.

FSM, states IDLE, HOLD, HOLD2:
- IDLE: output empty. `in_ready`=1. An accept moves to HOLD, or to HOLD2 for a two-beat LI.
- HOLD: one beat registered, `out_valid`=1, `out_last`=1.
  - Drain with no new accept → IDLE.
  - Drain with a simultaneous accept → HOLD/HOLD2 with the new beat.
- HOLD2: LUI beat registered, `out_last`=0. The ADDI word sits in a second register. Drain → HOLD with the ADDI word. `in_ready`=0.

## Timing
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready). It is combinational from `out_ready`.
- Latency: an accept at edge N presents the beat at N+1.
- Throughput: 1 instruction per cycle for single-beat requests; 2 cycles for a two-beat LI.
- All output fields are registered. `out_inst`, `out_last` and `out_err` are stable while `out_valid && !out_ready`.
- Reset (asynchronous, any state, including mid-LI):
  - state=IDLE, `out_valid`=0, `out_inst`=0, `out_last`=0, `out_err`=0.
  - A pending ADDI beat is discarded.
  - `in_ready` = 1 while `rst` is low after reset; it is held 0 while `rst`=1.
- Range checks and encoding are combinational in the accept cycle. No beat is emitted for a rejected input cycle.

## Test plan
- LI rd=5, imm=32'h12345678 → beat 32'h123452B7 (`out_last`=0), then 32'h67828293 (`out_last`=1). `in_ready`=0 during the first beat.
- LI rd=6, imm=32'h00000FFF → 32'h00001337, then 32'hFFF30313. LI rd=1, imm=32'hFFFFF800 → single beat 32'h80000093.
- B: opcode 7'h63, funct3 0, rs1=1, rs2=2, imm=−4 → 32'hFE208EE3. J: opcode 7'h6F, rd=1, imm=32'h800 → 32'h001000EF.
- J with imm=3, I with imm=2048, and fmt=7 → each gives 32'h00000013 with `out_err`=1, `out_last`=1.
- Back-to-back I-type requests with `out_ready` held low for 3 cycles, then high:
  - The first beat holds stable and `in_ready` stays 0 while stalled.
  - After release, one beat per cycle with no loss or duplication.
- Assert `rst` while in HOLD2 → `out_valid` falls to 0 immediately. After release, the next LI emits correctly, and the stale ADDI beat never appears.
